// File: rtl/pc_control.sv
// Program counter and branch resolution: evaluates B/BR conditions against the
// ALU flags, computes the next PC and owns the RUN/HALTED machine for HLT.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IMM_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [15:0]      reg_target,
  input  logic             N_Flag,
  input  logic             Z_Flag,
  input  logic             V_Flag,
  input  logic             stall,
  output logic [15:0]      pc_out,
  output logic [15:0]      pc_plus2,
  output logic             taken,
  output logic             flush,
  output logic             halt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      state, next_state;
  logic [15:0] pc, next_pc;
  logic        cond_true;
  logic [15:0] offset;
  logic        is_branch;

  // Word offset: sign-extend to 16 bits, then scale to bytes.
  assign offset    = {{(16-IMM_W){imm[IMM_W-1]}}, imm} << 1;
  assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
  assign pc_out    = pc;
  assign pc_plus2  = pc + 16'd2;
  assign halt      = (state == HALTED);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = ~Z_Flag;
      3'b001: cond_true = Z_Flag;
      3'b010: cond_true = ~Z_Flag & ~N_Flag;
      3'b011: cond_true = N_Flag;
      3'b100: cond_true = Z_Flag | (~Z_Flag & ~N_Flag);
      3'b101: cond_true = N_Flag | Z_Flag;
      3'b110: cond_true = V_Flag;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    next_pc    = pc;
    taken      = 1'b0;
    if (state == RUN && !stall) begin
      taken   = is_branch & cond_true;
      next_pc = pc_plus2;
      if (taken && opcode == OP_B)
        next_pc = pc_plus2 + offset;
      else if (taken && opcode == OP_BR)
        next_pc = reg_target;
      else if (opcode == OP_HLT) begin
        next_pc    = pc;
        next_state = HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      flush <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      flush <= taken;
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed stimulus, a behavioural PC model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_pc_control;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic        n_f, z_f, v_f;
  logic        stall;
  logic [15:0] pc_out, pc_plus2;
  logic        taken, flush, halt;

  int tests = 0;
  int fails = 0;

  pc_control #(.RESET_PC(16'h0000), .IMM_W(9)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .imm(imm),
    .reg_target(reg_target), .N_Flag(n_f), .Z_Flag(z_f), .V_Flag(v_f),
    .stall(stall), .pc_out(pc_out), .pc_plus2(pc_plus2), .taken(taken),
    .flush(flush), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC held as an integer, branch rules from the condition table.
  int m_pc;
  bit m_halted, m_flush, started;

  function automatic bit cond_holds(input logic [2:0] c, input bit n, input bit z, input bit v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit exp_taken();
    return !m_halted && !stall && (opcode == OP_B || opcode == OP_BR) &&
           cond_holds(cond, n_f, z_f, v_f);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_halted = 0; m_flush = 0; started = 1;
    end else begin
      int off;
      bit t;
      t       = exp_taken();
      m_flush = t;
      off     = imm[8] ? int'(imm) - 512 : int'(imm);
      if (!m_halted && !stall) begin
        if (opcode == OP_HLT)           m_halted = 1;
        else if (t && opcode == OP_B)   m_pc = (m_pc + 2 + 2 * off) & 16'hFFFF;
        else if (t && opcode == OP_BR)  m_pc = int'(reg_target);
        else                            m_pc = (m_pc + 2) & 16'hFFFF;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("pc_out", pc_out, m_pc[15:0]);
      check("pc_plus2", pc_plus2, 16'((m_pc + 2) & 16'hFFFF));
      check("flush", {15'd0, flush}, {15'd0, m_flush});
      check("halt", {15'd0, halt}, {15'd0, m_halted});
      if (!rst) check("taken", {15'd0, taken}, {15'd0, exp_taken()});
    end
  end

  task automatic step(input logic [3:0] op, input logic [2:0] c, input logic [8:0] im,
                      input logic [15:0] tgt, input logic [2:0] nzv, input logic st);
    opcode = op; cond = c; imm = im; reg_target = tgt;
    n_f = nzv[2]; z_f = nzv[1]; v_f = nzv[0]; stall = st;
    @(posedge clk); #1;
  endtask

  task automatic nop(); step(OP_NOP, 3'd0, 9'd0, 16'd0, 3'b000, 1'b0); endtask
  task automatic jump(input logic [15:0] t); step(OP_BR, 3'd7, 9'd0, t, 3'b000, 1'b0); endtask

  initial begin
    rst = 1'b1;
    opcode = OP_NOP; cond = 3'd0; imm = 9'd0; reg_target = 16'd0;
    n_f = 0; z_f = 0; v_f = 0; stall = 0;
    @(posedge clk); #1;
    check("reset_pc", pc_out, 16'h0000);
    check("reset_halt", {15'd0, halt}, 16'd0);
    rst = 1'b0;
    repeat (4) nop();
    check("seq_pc", pc_out, 16'h0008);

    jump(16'h0010);
    check("br_abs", pc_out, 16'h0010);
    step(OP_B, 3'd1, 9'h1FC, 16'd0, 3'b010, 1'b0);
    check("b_eq_taken", pc_out, 16'h000A);
    check("b_flush", {15'd0, flush}, 16'd1);
    jump(16'h0010);
    step(OP_B, 3'd1, 9'h1FC, 16'd0, 3'b000, 1'b0);
    check("b_eq_not", pc_out, 16'h0012);
    check("b_noflush", {15'd0, flush}, 16'd0);

    step(OP_BR, 3'd6, 9'd0, 16'h1234, 3'b001, 1'b0);
    check("br_ov", pc_out, 16'h1234);
    step(OP_BR, 3'd3, 9'd0, 16'h4444, 3'b000, 1'b0);
    check("br_lt_not", pc_out, 16'h1236);

    repeat (2) step(OP_B, 3'd7, 9'd4, 16'd0, 3'b000, 1'b1);
    check("stall_pc", pc_out, 16'h1236);
    step(OP_B, 3'd7, 9'd4, 16'd0, 3'b000, 1'b0);
    check("unstall_b", pc_out, 16'h1240);

    opcode = OP_PCS; stall = 0; #1;
    check("pcs_wb", pc_plus2, 16'h1242);
    step(OP_PCS, 3'd0, 9'd0, 16'd0, 3'b000, 1'b0);

    step(OP_BR, 3'd7, 9'd0, 16'h1235, 3'b000, 1'b0);
    check("br_odd", pc_out, 16'h1235);

    jump(16'h0020);
    step(OP_HLT, 3'd0, 9'd0, 16'd0, 3'b000, 1'b0);
    check("hlt_flag", {15'd0, halt}, 16'd1);
    repeat (2) nop();
    step(OP_B, 3'd7, 9'd8, 16'd0, 3'b000, 1'b0);
    step(OP_BR, 3'd7, 9'd0, 16'h5555, 3'b000, 1'b0);
    nop();
    check("halted_pc", pc_out, 16'h0020);
    rst = 1'b1; nop(); rst = 1'b0;
    check("rst_exit_pc", pc_out, 16'h0000);
    check("rst_exit_halt", {15'd0, halt}, 16'd0);

    jump(16'hFFFE);
    nop();
    check("wrap_up", pc_out, 16'h0000);
    jump(16'h0002);
    step(OP_B, 3'd7, 9'h1FE, 16'd0, 3'b000, 1'b0);
    check("wrap_back", pc_out, 16'h0000);

    // Sweep every condition code against every flag combination.
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        step(OP_B, 3'(c), 9'd0, 16'd0, 3'(f), 1'b0);
    nop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
